// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types, defaults and branch target helper
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

  // Relative displacement is in words; both forms wrap mod 2^32 and are word aligned.
  function automatic logic [31:0] branch_target(
    input logic        br_abs,
    input logic [31:0] br_pc,
    input logic [15:0] br_rel,
    input logic [31:0] br_base,
    input logic [15:0] br_offset
  );
    logic [31:0] t;
    if (br_abs) t = br_base + {{16{br_offset[15]}}, br_offset};
    else        t = br_pc + {{14{br_rel[15]}}, br_rel, 2'b00};
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// rtl/fetch_target_calc.sv - combinational branch target adder with word alignment
module fetch_target_calc
  import fetch_pkg::*;
(
  input  logic        br_abs_i,
  input  logic [31:0] br_pc_i,
  input  logic [15:0] br_rel_i,
  input  logic [31:0] br_base_i,
  input  logic [15:0] br_offset_i,
  output logic [31:0] target_o
);

  assign target_o = branch_target(br_abs_i, br_pc_i, br_rel_i, br_base_i, br_offset_i);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, single-outstanding IM request, IF/ID handoff
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] PC_STEP  = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic        br_abs,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_rel,
  input  logic [31:0] br_base,
  input  logic [15:0] br_offset
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inflight_q;
  logic         drop_q;
  logic         im_req_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  br_target;
  logic [31:0]  pc_d;

  fetch_target_calc u_target (
    .br_abs_i   (br_abs),
    .br_pc_i    (br_pc),
    .br_rel_i   (br_rel),
    .br_base_i  (br_base),
    .br_offset_i(br_offset),
    .target_o   (br_target)
  );

  assign pc_d = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pc_inflight_q <= '0;
      drop_q        <= 1'b0;
      im_req_q      <= 1'b0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
    end else if (br_taken) begin
      pc_q       <= br_target;
      if_valid_q <= 1'b0;
      // A request already handed to IM must have its response swallowed before refetching.
      if (state_q == ST_WAIT && !im_rvalid) begin
        drop_q   <= 1'b1;
        im_req_q <= 1'b0;
      end else if (state_q == ST_REQ && im_gnt) begin
        state_q  <= ST_WAIT;
        drop_q   <= 1'b1;
        im_req_q <= 1'b0;
      end else begin
        state_q  <= ST_REQ;
        drop_q   <= 1'b0;
        im_req_q <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_REQ;
          im_req_q <= 1'b1;
        end
        ST_REQ: begin
          if (im_gnt) begin
            state_q       <= ST_WAIT;
            pc_inflight_q <= pc_q;
            im_req_q      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (im_rvalid) begin
            if (drop_q) begin
              drop_q   <= 1'b0;
              state_q  <= ST_REQ;
              im_req_q <= 1'b1;
            end else begin
              if_instr_q <= im_rdata;
              if_pc_q    <= pc_inflight_q;
              if_valid_q <= 1'b1;
              pc_q       <= pc_d;
              state_q    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= ST_REQ;
            im_req_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          im_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign im_req   = im_req_q;
  assign im_addr  = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with IM model and fetch-order reference
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_abs = 1'b0;
  logic [31:0] br_pc = '0;
  logic [15:0] br_rel = '0;
  logic [31:0] br_base = '0;
  logic [15:0] br_offset = '0;

  fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .br_taken(br_taken), .br_abs(br_abs), .br_pc(br_pc), .br_rel(br_rel),
    .br_base(br_base), .br_offset(br_offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // IM model state: one pending request with a countdown to its response
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_target(input logic abs, input logic [31:0] pc,
                                             input logic [15:0] rel, input logic [31:0] base,
                                             input logic [15:0] off);
    longint t;
    if (abs) t = longint'(base) + longint'($signed(off));
    else     t = longint'(pc) + 4 * longint'($signed(rel));
    return 32'(t) & 32'hFFFF_FFFC;
  endfunction

  task automatic drive_im();
    im_rvalid = pend && (pend_cnt == 0);
    im_rdata  = im_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic step();
    logic        issue;
    logic        consumed;
    logic [31:0] a;
    issue    = im_req && im_gnt;
    consumed = im_rvalid;
    a        = im_addr;
    @(posedge clk); #1;
    if (consumed) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (issue) begin
      pend      = 1'b1;
      pend_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
      pend_addr = a;
    end
    drive_im();
  endtask

  task automatic do_reset();
    rst = 1'b1; im_gnt = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_abs = 1'b0;
    br_pc = '0; br_rel = '0; br_base = '0; br_offset = '0;
    pend = 1'b0; pend_cnt = 0; lat_min = 1; lat_max = 1;
    drive_im();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (im_req !== 1'b0) $display("FAIL reset_im_req: got %b exp 0", im_req); else passes++;
    checks++; if (im_addr !== 32'h0) $display("FAIL reset_im_addr: got %h exp 0", im_addr); else passes++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b exp 0", if_valid); else passes++;
    checks++; if (if_instr !== 32'h0) $display("FAIL reset_if_instr: got %h exp 0", if_instr); else passes++;
    checks++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h exp 0", if_pc); else passes++;
  endtask

  task automatic test_sequential();
    int n_iss = 0;
    int n_hand = 0;
    do_reset();
    id_ready = 1'b1; im_gnt = 1'b1;
    for (int c = 0; c < 40 && n_hand < 4; c++) begin
      if (im_req && im_gnt) begin
        checks++;
        if (im_addr !== 32'(4 * n_iss)) $display("FAIL seq_addr: got %h exp %h", im_addr, 32'(4 * n_iss));
        else passes++;
        n_iss++;
      end
      if (if_valid && id_ready) begin
        checks++;
        if (if_pc !== 32'(4 * n_hand) || if_instr !== mem_word(32'(4 * n_hand)))
          $display("FAIL seq_handoff: got pc %h instr %h exp pc %h instr %h",
                   if_pc, if_instr, 32'(4 * n_hand), mem_word(32'(4 * n_hand)));
        else passes++;
        n_hand++;
      end
      step();
    end
    checks++; if (n_hand !== 4) $display("FAIL seq_timeout: got %0d handoffs exp 4", n_hand); else passes++;
  endtask

  task automatic test_gnt_stall();
    int  c;
    logic got;
    do_reset();
    id_ready = 1'b1; im_gnt = 1'b1;
    for (c = 0; c < 30 && !(im_req && im_addr == 32'h8); c++) step();
    checks++; if (!(im_req && im_addr == 32'h8)) $display("FAIL stall_reach: got addr %h exp 00000008", im_addr); else passes++;
    im_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (im_req !== 1'b1 || im_addr !== 32'h8 || pend !== 1'b0)
        $display("FAIL stall_hold: got req %b addr %h issued %b exp 1 00000008 0", im_req, im_addr, pend);
      else passes++;
    end
    im_gnt = 1'b1;
    got = 1'b0;
    for (c = 0; c < 20 && !got; c++) begin
      if (if_valid && id_ready) begin
        got = 1'b1;
        checks++;
        if (if_pc !== 32'h8 || if_instr !== mem_word(32'h8))
          $display("FAIL stall_resp: got pc %h instr %h exp 00000008 %h", if_pc, if_instr, mem_word(32'h8));
        else passes++;
      end
      step();
    end
    checks++; if (!got) $display("FAIL stall_timeout: got no handoff exp one"); else passes++;
  endtask

  task automatic test_hold();
    logic [31:0] pc0;
    logic [31:0] in0;
    do_reset();
    id_ready = 1'b0; im_gnt = 1'b1;
    for (int c = 0; c < 20 && !if_valid; c++) step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0))
      $display("FAIL hold_first: got v %b pc %h instr %h exp 1 00000000 %h", if_valid, if_pc, if_instr, mem_word(32'h0));
    else passes++;
    pc0 = if_pc; in0 = if_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== pc0 || if_instr !== in0 || im_req !== 1'b0)
        $display("FAIL hold_stable: got v %b pc %h instr %h req %b exp 1 %h %h 0", if_valid, if_pc, if_instr, im_req, pc0, in0);
      else passes++;
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h4)
      $display("FAIL hold_release: got v %b req %b addr %h exp 0 1 00000004", if_valid, im_req, im_addr);
    else passes++;
  endtask

  task automatic test_redirect_wait();
    logic got;
    do_reset();
    lat_min = 3; lat_max = 3;
    id_ready = 1'b1; im_gnt = 1'b1;
    for (int c = 0; c < 60 && !(im_req && im_addr == 32'h10); c++) step();
    checks++; if (!(im_req && im_addr == 32'h10)) $display("FAIL rw_reach: got addr %h exp 00000010", im_addr); else passes++;
    step();
    br_taken = 1'b1; br_abs = 1'b0; br_pc = 32'h8; br_rel = 16'hFFFE;
    step();
    br_taken = 1'b0;
    checks++;
    if (im_req !== 1'b0 || if_valid !== 1'b0)
      $display("FAIL rw_drop_wait: got req %b v %b exp 0 0", im_req, if_valid);
    else passes++;
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 20 && !im_req; c++) begin
      checks++; if (if_valid !== 1'b0) $display("FAIL rw_stale_shown: got v %b pc %h exp 0", if_valid, if_pc); else passes++;
      step();
    end
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h0 || pend !== 1'b0)
      $display("FAIL rw_refetch: got req %b addr %h pending %b exp 1 00000000 0", im_req, im_addr, pend);
    else passes++;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (if_valid && id_ready) begin
        got = 1'b1;
        checks++;
        if (if_pc !== 32'h0 || if_instr !== mem_word(32'h0))
          $display("FAIL rw_handoff: got pc %h instr %h exp 00000000 %h", if_pc, if_instr, mem_word(32'h0));
        else passes++;
      end
      step();
    end
    checks++; if (!got) $display("FAIL rw_timeout: got no handoff exp one"); else passes++;
  endtask

  task automatic test_redirect_rvalid();
    logic got;
    do_reset();
    lat_min = 2; lat_max = 2;
    id_ready = 1'b1; im_gnt = 1'b1;
    for (int c = 0; c < 20 && !im_rvalid; c++) step();
    checks++; if (im_rvalid !== 1'b1) $display("FAIL rv_reach: got rvalid %b exp 1", im_rvalid); else passes++;
    br_taken = 1'b1; br_abs = 1'b1; br_base = 32'h100; br_offset = 16'h0020;
    step();
    br_taken = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h120)
      $display("FAIL rv_discard: got v %b req %b addr %h exp 0 1 00000120", if_valid, im_req, im_addr);
    else passes++;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (if_valid && id_ready) begin
        got = 1'b1;
        checks++;
        if (if_pc !== 32'h120 || if_instr !== mem_word(32'h120))
          $display("FAIL rv_handoff: got pc %h instr %h exp 00000120 %h", if_pc, if_instr, mem_word(32'h120));
        else passes++;
      end
      step();
    end
    checks++; if (!got) $display("FAIL rv_timeout: got no handoff exp one"); else passes++;
  endtask

  task automatic test_reset_wait();
    logic got;
    do_reset();
    lat_min = 4; lat_max = 4;
    id_ready = 1'b1; im_gnt = 1'b1;
    for (int c = 0; c < 60 && !(im_req && im_addr == 32'h8); c++) step();
    step();
    step();
    checks++;
    if (if_pc !== 32'h4 || im_addr !== 32'h8 || im_req !== 1'b0)
      $display("FAIL rst_setup: got pc %h addr %h req %b exp 00000004 00000008 0", if_pc, im_addr, im_req);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (im_req !== 1'b0 || im_addr !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0)
      $display("FAIL rst_async: got req %b addr %h v %b instr %h pc %h exp all 0",
               im_req, im_addr, if_valid, if_instr, if_pc);
    else passes++;
    pend = 1'b0; lat_min = 1; lat_max = 1;
    drive_im();
    @(posedge clk); #1;
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (if_valid && id_ready) begin
        got = 1'b1;
        checks++;
        if (if_pc !== 32'h0 || if_instr !== mem_word(32'h0))
          $display("FAIL rst_restart: got pc %h instr %h exp 00000000 %h", if_pc, if_instr, mem_word(32'h0));
        else passes++;
      end
      step();
    end
    checks++; if (!got) $display("FAIL rst_timeout: got no handoff exp one"); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_stall = 1'b0;
    int          hand = 0;
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      im_gnt   = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 19) == 0);
      br_abs   = 1'($urandom_range(0, 1));
      br_pc    = $urandom;
      br_rel   = 16'($urandom);
      br_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
      br_offset = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      if (prev_stall) begin
        checks++;
        if (im_req !== 1'b1 || im_addr !== prev_addr)
          $display("FAIL rnd_stall: got req %b addr %h exp 1 %h", im_req, im_addr, prev_addr);
        else passes++;
      end
      if (im_req) begin
        checks++; if (pend !== 1'b0) $display("FAIL rnd_outstanding: got pending %b exp 0", pend); else passes++;
      end
      if (im_req && im_gnt) begin
        checks++; if (im_addr !== exp_pc) $display("FAIL rnd_issue: got %h exp %h", im_addr, exp_pc); else passes++;
      end
      if (if_valid && id_ready) begin
        checks++;
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc))
          $display("FAIL rnd_handoff: got pc %h instr %h exp pc %h instr %h", if_pc, if_instr, exp_pc, mem_word(exp_pc));
        else passes++;
        exp_pc = exp_pc + 32'd4;
        hand++;
      end
      if (br_taken) exp_pc = ref_target(br_abs, br_pc, br_rel, br_base, br_offset);
      prev_stall = im_req && !im_gnt && !br_taken;
      prev_addr  = im_addr;
      step();
    end
    br_taken = 1'b0;
    checks++; if (hand < 100) $display("FAIL rnd_progress: got %0d handoffs exp >= 100", hand); else passes++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_gnt_stall();
    test_hold();
    test_redirect_wait();
    test_redirect_rvalid();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
